blob_box_exporter: RTL and testbench

- Sequences export of the per-frame bounding-box table produced by blob segmentation to a downstream link: host UART/Ethernet packetiser or an overlay consumer.
- Double-buffers the 15-entry box table so that segmentation of frame N+1 overlaps streaming of frame N.
- Emits frame N as a framed word stream (header, boxes, trailer) over a valid/ready handshake.
- Drops whole frames, and counts them, when the consumer is too slow.

---
 rtl/blob_box_exporter_pkg.sv | 36 +++
 rtl/blob_box_exporter_pick_next.sv | 25 ++
 rtl/blob_box_exporter.sv | 121 ++++++++++++
 tb/tb_blob_box_exporter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blob_box_exporter_pkg.sv
// rtl/blob_box_exporter_pkg.sv - shared sizes, word tags, FSM states and helpers for the box exporter
package blob_box_exporter_pkg;

   function automatic int ceil_log2(input int n);
      int r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   localparam int MAX_OBJ = 15;
   localparam int B_BITS  = ceil_log2(MAX_OBJ);
   localparam int H_BITS  = 10;
   localparam int V_BITS  = 9;
   localparam int BOX_W   = 2 * (H_BITS + V_BITS);
   localparam int FID_W   = 16;
   localparam int OUT_W   = BOX_W + 2;
   localparam int HDR_PAD = BOX_W - FID_W - B_BITS - 8;

   localparam logic [1:0] TAG_HDR = 2'b01;
   localparam logic [1:0] TAG_BOX = 2'b10;
   localparam logic [1:0] TAG_TRL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_BOX  = 2'd2,
      ST_TRL  = 2'd3
   } state_t;

   function automatic logic [B_BITS-1:0] popcount(input logic [MAX_OBJ-1:0] m);
      logic [B_BITS-1:0] c = '0;
      for (int i = 0; i < MAX_OBJ; i++) c = c + {{(B_BITS-1){1'b0}}, m[i]};
      return c;
   endfunction

endpackage

// File: rtl/blob_box_exporter_pick_next.sv
// rtl/blob_box_exporter_pick_next.sv - lowest-set-bit priority encoder over a slot mask
module box_pick_next
   import blob_box_exporter_pkg::*;
#(
   parameter int N  = MAX_OBJ,
   parameter int IW = B_BITS
) (
   input  logic [N-1:0]  mask,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scanning from the top down lets the lowest set bit win the last assignment.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx = IW'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/blob_box_exporter.sv
// rtl/blob_box_exporter.sv - double-buffered box table streamed as HDR/BOX/TRL words
module blob_box_exporter
   import blob_box_exporter_pkg::*;
(
   input  logic               app_clk,
   input  logic               app_rst,
   input  logic               box_wr_en,
   input  logic [B_BITS-1:0]  box_wr_idx,
   input  logic [BOX_W-1:0]   box_wr_data,
   input  logic               frame_done,
   input  logic [MAX_OBJ-1:0] frame_mask,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_data,
   output logic               busy,
   output logic [FID_W-1:0]   frame_id,
   output logic [7:0]         drop_count
);

   state_t             state, state_nxt;
   logic [BOX_W-1:0]   bank_q [2][MAX_OBJ];
   logic               wr_bank, rd_bank;
   logic [MAX_OBJ-1:0] rd_mask;
   logic [FID_W-1:0]   cur_fid, fid_inc;
   logic               accept, fd_accept, load, pop, pick_any;
   logic [B_BITS-1:0]  pick_idx;
   logic [OUT_W-1:0]   word_nxt, hdr_word, trl_word, box_word;

   assign accept    = out_valid & out_ready;
   assign fd_accept = frame_done & ((state == ST_IDLE) | ((state == ST_TRL) & accept));
   assign rd_bank   = ~wr_bank;
   assign fid_inc   = frame_id + FID_W'(1);
   assign busy      = (state != ST_IDLE);

   // rd_mask holds only the boxes not yet loaded into out_data, so one picker serves HDR and BOX.
   box_pick_next #(.N(MAX_OBJ), .IW(B_BITS)) u_pick (
      .mask (rd_mask),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // Header fields are snapshotted when the word is loaded, keeping it stable under backpressure.
   assign hdr_word = {TAG_HDR, fid_inc, popcount(frame_mask), drop_count, {HDR_PAD{1'b0}}};
   assign trl_word = {TAG_TRL, cur_fid, {(BOX_W - FID_W){1'b0}}};
   assign box_word = {TAG_BOX, bank_q[rd_bank][pick_idx]};

   always_ff @(posedge app_clk) begin
      if (box_wr_en && (box_wr_idx < B_BITS'(MAX_OBJ))) bank_q[wr_bank][box_wr_idx] <= box_wr_data;
   end

   always_ff @(posedge app_clk or posedge app_rst) begin
      if (app_rst) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      pop       = 1'b0;
      word_nxt  = out_data;
      case (state)
         ST_IDLE: begin
            if (fd_accept) begin
               state_nxt = ST_HDR;
               load      = 1'b1;
               word_nxt  = hdr_word;
            end
         end
         ST_HDR, ST_BOX: begin
            if (accept) begin
               load = 1'b1;
               if (pick_any) begin
                  pop       = 1'b1;
                  state_nxt = ST_BOX;
                  word_nxt  = box_word;
               end else begin
                  state_nxt = ST_TRL;
                  word_nxt  = trl_word;
               end
            end
         end
         ST_TRL: begin
            if (accept) begin
               if (fd_accept) begin
                  state_nxt = ST_HDR;
                  load      = 1'b1;
                  word_nxt  = hdr_word;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge app_clk or posedge app_rst) begin
      if (app_rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         wr_bank    <= 1'b0;
         rd_mask    <= '0;
         cur_fid    <= '0;
         frame_id   <= '0;
         drop_count <= '0;
      end else begin
         out_valid <= (state_nxt != ST_IDLE);
         if (load) out_data <= word_nxt;
         if (frame_done) frame_id <= fid_inc;
         if (fd_accept) begin
            wr_bank <= ~wr_bank;
            rd_mask <= frame_mask;
            cur_fid <= fid_inc;
         end else if (pop) begin
            rd_mask <= rd_mask & ~(MAX_OBJ'(1) << pick_idx);
         end
         if (frame_done && !fd_accept && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_blob_box_exporter.sv
// tb/tb_blob_box_exporter.sv - scoreboard bench for blob_box_exporter
module tb_blob_box_exporter;
   import blob_box_exporter_pkg::*;

   logic               app_clk = 1'b0;
   logic               app_rst = 1'b1;
   logic               box_wr_en = 1'b0;
   logic [B_BITS-1:0]  box_wr_idx = '0;
   logic [BOX_W-1:0]   box_wr_data = '0;
   logic               frame_done = 1'b0;
   logic [MAX_OBJ-1:0] frame_mask = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [OUT_W-1:0]   out_data;
   logic               busy;
   logic [FID_W-1:0]   frame_id;
   logic [7:0]         drop_count;

   int checks = 0;
   int errors = 0;
   logic [OUT_W-1:0] exp_q [$];
   logic             hold_pending = 1'b0;
   logic [OUT_W-1:0] held = '0;

   blob_box_exporter dut (
      .app_clk     (app_clk),
      .app_rst     (app_rst),
      .box_wr_en   (box_wr_en),
      .box_wr_idx  (box_wr_idx),
      .box_wr_data (box_wr_data),
      .frame_done  (frame_done),
      .frame_mask  (frame_mask),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy),
      .frame_id    (frame_id),
      .drop_count  (drop_count)
   );

   always #5 app_clk = ~app_clk;

   function automatic logic [BOX_W-1:0] bv(input int p, input int i);
      return {6'(p * 8 + i), 32'(32'hA5A5_0000 + p * 256 + i)};
   endfunction

   function automatic logic [OUT_W-1:0] hdr(input int fid, input int cnt, input int drop);
      return {2'b01, 16'(fid), 4'(cnt), 8'(drop), 10'b0};
   endfunction

   function automatic logic [OUT_W-1:0] trl(input int fid);
      return {2'b11, 16'(fid), 22'b0};
   endfunction

   function automatic logic [OUT_W-1:0] bw(input logic [BOX_W-1:0] d);
      return {2'b10, d};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge app_clk);
      #1;
   endtask

   task automatic wr_box(input int idx, input logic [BOX_W-1:0] d);
      box_wr_en   = 1'b1;
      box_wr_idx  = B_BITS'(idx);
      box_wr_data = d;
      tick();
      box_wr_en   = 1'b0;
   endtask

   task automatic pulse_fd(input logic [MAX_OBJ-1:0] m);
      frame_done = 1'b1;
      frame_mask = m;
      tick();
      frame_done = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 200) begin
         tick();
         n++;
      end
      check(name, 64'(n < 200), 64'd1);
   endtask

   task automatic wait_tag(input logic [1:0] tag, input string name);
      int n = 0;
      while (!(out_valid && out_data[OUT_W-1 -: 2] == tag) && n < 100) begin
         tick();
         n++;
      end
      check(name, 64'(n < 100), 64'd1);
   endtask

   task automatic monitor();
      forever begin
         @(negedge app_clk);
         if (app_rst) begin
            hold_pending = 1'b0;
         end else begin
            if (hold_pending) begin
               check("hold_valid", 64'(out_valid), 64'd1);
               check("hold_data", 64'(out_data), 64'(held));
            end
            if (out_valid && out_ready) begin
               hold_pending = 1'b0;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word actual=%0h required=none", out_data);
               end else begin
                  check("stream_word", 64'(out_data), 64'(exp_q.pop_front()));
               end
            end else if (out_valid) begin
               hold_pending = 1'b1;
               held = out_data;
            end else begin
               hold_pending = 1'b0;
            end
         end
      end
   endtask

   initial begin
      fork
         monitor();
      join_none

      tick();
      tick();
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data", 64'(out_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_fid", 64'(frame_id), 64'd0);
      check("rst_drop", 64'(drop_count), 64'd0);
      app_rst = 1'b0;
      tick();

      // frame 1: slots 0 and 3
      out_ready = 1'b1;
      wr_box(0, bv(1, 0));
      wr_box(3, bv(1, 3));
      exp_q.push_back(hdr(1, 2, 0));
      exp_q.push_back(bw(bv(1, 0)));
      exp_q.push_back(bw(bv(1, 3)));
      exp_q.push_back(trl(1));
      pulse_fd(15'h0009);
      check("f1_latency", 64'(out_valid), 64'd1);
      wait_idle("f1_drain");
      check("f1_busy", 64'(busy), 64'd0);
      check("f1_valid", 64'(out_valid), 64'd0);
      check("f1_fid", 64'(frame_id), 64'd1);

      // frame 2: empty mask
      exp_q.push_back(hdr(2, 0, 0));
      exp_q.push_back(trl(2));
      pulse_fd(15'h0000);
      wait_idle("f2_drain");

      // frame 3: stall 10 cycles on the first box
      wr_box(1, bv(3, 1));
      wr_box(2, bv(3, 2));
      wr_box(7, bv(3, 7));
      exp_q.push_back(hdr(3, 3, 0));
      exp_q.push_back(bw(bv(3, 1)));
      exp_q.push_back(bw(bv(3, 2)));
      exp_q.push_back(bw(bv(3, 7)));
      exp_q.push_back(trl(3));
      pulse_fd(15'h0086);
      wait_tag(TAG_BOX, "f3_box");
      out_ready = 1'b0;
      repeat (10) tick();
      check("f3_stall_data", 64'(out_data), 64'(bw(bv(3, 1))));
      out_ready = 1'b1;
      wait_idle("f3_drain");

      // frame 4 held under backpressure, frames 5 and 6 dropped
      out_ready = 1'b0;
      wr_box(4, bv(4, 4));
      exp_q.push_back(hdr(4, 1, 0));
      exp_q.push_back(bw(bv(4, 4)));
      exp_q.push_back(trl(4));
      pulse_fd(15'h0010);
      tick();
      pulse_fd(15'h7FFF);
      tick();
      pulse_fd(15'h0001);
      check("f4_drop", 64'(drop_count), 64'd2);
      check("f4_fid", 64'(frame_id), 64'd6);
      check("f4_held", 64'(out_data), 64'(hdr(4, 1, 0)));
      out_ready = 1'b1;
      wait_idle("f4_drain");

      // frame 7, then frame 8 back-to-back with a same-cycle write into slot 5
      wr_box(2, bv(7, 2));
      exp_q.push_back(hdr(7, 1, 2));
      exp_q.push_back(bw(bv(7, 2)));
      exp_q.push_back(trl(7));
      exp_q.push_back(hdr(8, 1, 2));
      exp_q.push_back(bw(bv(8, 5)));
      exp_q.push_back(trl(8));
      pulse_fd(15'h0004);
      wait_tag(TAG_TRL, "f7_trl");
      box_wr_en   = 1'b1;
      box_wr_idx  = 4'd5;
      box_wr_data = bv(8, 5);
      pulse_fd(15'h0020);
      box_wr_en   = 1'b0;
      check("b2b_valid", 64'(out_valid), 64'd1);
      check("b2b_tag", 64'(out_data[OUT_W-1 -: 2]), 64'(TAG_HDR));
      check("b2b_drop", 64'(drop_count), 64'd2);
      wait_idle("f8_drain");

      // frame 9 aborted by reset in the middle of BOX
      for (int i = 0; i < 4; i++) wr_box(i, bv(9, i));
      exp_q.push_back(hdr(9, 4, 2));
      pulse_fd(15'h000F);
      wait_tag(TAG_BOX, "f9_box");
      out_ready = 1'b0;
      #3;
      app_rst = 1'b1;
      #1;
      check("abort_valid", 64'(out_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_queue", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      tick();
      app_rst = 1'b0;
      out_ready = 1'b1;
      wr_box(0, bv(10, 0));
      wr_box(1, bv(10, 1));
      exp_q.push_back(hdr(1, 2, 0));
      exp_q.push_back(bw(bv(10, 0)));
      exp_q.push_back(bw(bv(10, 1)));
      exp_q.push_back(trl(1));
      pulse_fd(15'h0003);
      wait_idle("f10_drain");
      check("f10_fid", 64'(frame_id), 64'd1);
      check("f10_drop", 64'(drop_count), 64'd0);
      check("final_queue", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
